// File: rtl/ripple_seq_pkg.sv
`default_nettype none
// ripple_seq_pkg: shared state encoding and mode constants for the ripple
// sequencer controller and its prescaler.
package ripple_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic ONE_SHOT    = 1'b0;
   localparam logic AUTO_RELOAD = 1'b1;
   localparam logic DIR_UP      = 1'b0;
   localparam logic DIR_DOWN    = 1'b1;

endpackage
`default_nettype wire

// File: rtl/ripple_seq_prescaler.sv
`default_nettype none
// ripple_seq_prescaler: divides the run enable down to one step pulse every
// prescale+1 enabled cycles; holds its phase while en is low.
module ripple_seq_prescaler #(
   parameter int PRE_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic [PRE_W-1:0] prescale,
   output logic             step
);

   logic [PRE_W-1:0] r_cnt;

   // Step is combinational so the controller acts on it in the same edge
   // that restarts the phase counter.
   assign step = en && (r_cnt == prescale);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         r_cnt <= '0;
      end else if (en) begin
         if (step) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/ripple_seq_ctrl.sv
`default_nettype none
// ripple_seq_ctrl: commandable synchronous count sequencer with prescaler,
// up/down direction, terminal limit and one-shot / auto-reload modes.
module ripple_seq_ctrl
   import ripple_seq_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int PRE_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_we,
   input  logic [WIDTH-1:0] cfg_limit,
   input  logic [PRE_W-1:0] cfg_prescale,
   input  logic             cfg_reload,
   input  logic             cfg_down,
   input  logic             start,
   input  logic             stop,
   input  logic             pause,
   output logic [WIDTH-1:0] count,
   output logic             tick,
   output logic             done,
   output logic             wrap,
   output logic             busy,
   output logic             cfg_err
);

   state_t           r_state;
   logic [WIDTH-1:0] r_limit;
   logic [PRE_W-1:0] r_prescale;
   logic             r_reload;
   logic             r_down;
   logic [WIDTH-1:0] r_count;
   logic             r_tick;
   logic             r_done;
   logic             r_wrap;
   logic             r_busy;
   logic             r_cfg_err;

   logic             w_active;
   logic             w_step_en;
   logic             w_clr;
   logic             w_step;
   logic [WIDTH-1:0] w_start_val;
   logic [WIDTH-1:0] w_term_val;

   assign w_active    = (r_state == RUN) || (r_state == HOLD);
   // Stop and pause both outrank a step that happens to be due this cycle.
   assign w_step_en   = w_active && !stop && !pause;
   assign w_clr       = start && !w_active;
   assign w_start_val = (r_down == DIR_DOWN) ? r_limit : '0;
   assign w_term_val  = (r_down == DIR_DOWN) ? '0 : r_limit;

   ripple_seq_prescaler #(
      .PRE_W(PRE_W)
   ) u_prescaler (
      .clk      (clk),
      .rst      (rst),
      .clr      (w_clr),
      .en       (w_step_en),
      .prescale (r_prescale),
      .step     (w_step)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_limit    <= '0;
         r_prescale <= '0;
         r_reload   <= ONE_SHOT;
         r_down     <= DIR_UP;
         r_count    <= '0;
         r_tick     <= 1'b0;
         r_done     <= 1'b0;
         r_wrap     <= 1'b0;
         r_busy     <= 1'b0;
         r_cfg_err  <= 1'b0;
      end else begin
         r_tick    <= 1'b0;
         r_done    <= 1'b0;
         r_wrap    <= 1'b0;
         r_cfg_err <= 1'b0;

         // A start in the same cycle as a write still uses the old config.
         if (cfg_we) begin
            if (w_active) begin
               r_cfg_err <= 1'b1;
            end else begin
               r_limit    <= cfg_limit;
               r_prescale <= cfg_prescale;
               r_reload   <= cfg_reload;
               r_down     <= cfg_down;
            end
         end

         case (r_state)
            IDLE, DONE: begin
               if (start) begin
                  r_state <= RUN;
                  r_busy  <= 1'b1;
                  r_count <= w_start_val;
               end
            end
            RUN, HOLD: begin
               if (stop) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end else if (pause) begin
                  r_state <= HOLD;
               end else begin
                  r_state <= RUN;
                  if (w_step) begin
                     r_tick <= 1'b1;
                     if (r_count == w_term_val) begin
                        if (r_reload == AUTO_RELOAD) begin
                           r_count <= w_start_val;
                           r_wrap  <= 1'b1;
                        end else begin
                           r_state <= DONE;
                           r_busy  <= 1'b0;
                           r_done  <= 1'b1;
                        end
                     end else if (r_down == DIR_DOWN) begin
                        r_count <= r_count - 1'b1;
                     end else begin
                        r_count <= r_count + 1'b1;
                     end
                  end
               end
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign count   = r_count;
   assign tick    = r_tick;
   assign done    = r_done;
   assign wrap    = r_wrap;
   assign busy    = r_busy;
   assign cfg_err = r_cfg_err;

endmodule
`default_nettype wire

// File: doc/ripple_seq_ctrl.md
# ripple_seq_ctrl

Sequencer that owns a WIDTH-bit count register and controls when it advances. It supplies start/stop/pause control, a programmable prescaler, up/down direction, a terminal limit, and one-shot or auto-reload modes. It sits between software-visible control strobes and any logic that consumes a paced count value, replacing free-running ripple counting with a fully synchronous, commandable counter.

## Interface
Parameters:
- WIDTH, 4, count width
- PRE_W, 8, prescaler width

Ports:
- clk, in, 1, single clock, all state on rising edge
- rst, in, 1, synchronous, active-high reset
- cfg_we, in, 1, configuration write strobe
- cfg_limit, in, WIDTH, terminal value
- cfg_prescale, in, PRE_W, step period minus one
- cfg_reload, in, 1, 0 = one-shot, 1 = auto-reload
- cfg_down, in, 1, 0 = count up, 1 = count down
- start, in, 1, start pulse
- stop, in, 1, abort pulse
- pause, in, 1, level; freezes counting while high
- count, out, WIDTH, current count
- tick, out, 1, one-cycle pulse per count step
- done, out, 1, one-cycle pulse on one-shot completion
- wrap, out, 1, one-cycle pulse on auto-reload
- busy, out, 1, high in RUN or HOLD
- cfg_err, out, 1, one-cycle pulse when cfg_we arrives while busy

## Operation
- States:
  - IDLE: after reset.
  - RUN
  - HOLD: paused.
  - DONE: one-shot finished.
- Configuration register (limit, prescale, reload, down):
  - Written on cfg_we in IDLE or DONE only.
  - In RUN or HOLD, the write is dropped and cfg_err pulses.
  - Reset value of the configuration is all zero.
- Start value: 0 when counting up, limit when counting down.
- Terminal value: limit when counting up, 0 when counting down.
- IDLE/DONE + start → RUN. In the same edge, count loads the start value and the prescaler clears.
- RUN:
  - The prescaler increments each cycle.
  - A step occurs in a cycle where prescaler == prescale; that edge clears the prescaler.
- On a step when count != terminal: count ±1 and tick=1.
- On a step when count == terminal:
  - One-shot: → DONE; count holds the terminal value; tick=1, done=1.
  - Auto-reload: count reloads the start value; tick=1, wrap=1; stays in RUN.
- RUN + pause → HOLD; prescaler and count are frozen. HOLD + !pause → RUN, resuming the prescaler where it left off.
- RUN/HOLD + stop → IDLE with count held. In IDLE or DONE, stop has no effect.
- Priority in the same cycle: rst > stop > start > pause.
  - start while in RUN or HOLD is ignored.
  - start with pause high enters RUN; HOLD follows on the next cycle if pause is still high.
- limit = 0: the first step is terminal (done or wrap on the first tick).
- Arithmetic is modulo 2^WIDTH, but wrap-around past the limit cannot occur because the terminal check precedes increment/decrement.
- rst in any state, including mid-RUN: next cycle is IDLE with count=0, configuration zeroed, all pulses 0, busy=0.

## Timing
- All outputs are registered. Reset values: count=0, tick=0, done=0, wrap=0, busy=0, cfg_err=0.
- Start sampled at edge N:
  - busy=1 and count=start value from N+1.
  - First step evaluated in the cycle after edge N+1+prescale.
  - With prescale=0, count changes every cycle after the first.
- Step period is prescale+1 cycles. tick, done and wrap assert in the same cycle the updated count is visible, for exactly one cycle.
- Entry to DONE: busy drops in the same cycle done asserts.
- A pause that rises in the cycle a step is due blocks that step.
- cfg_err asserts the cycle after the offending cfg_we.

## Structure
- Package ripple_seq_pkg:
  - State enum (IDLE, RUN, HOLD, DONE), 2-bit.
  - Mode constants (ONE_SHOT, AUTO_RELOAD, DIR_UP, DIR_DOWN).
- Sub-module ripple_seq_prescaler:
  - Inputs: clr, en, prescale.
  - Output: step pulse.
- The top block holds the FSM, configuration register, count register and output pulse registers.

## Test plan
- Up one-shot: limit=3, prescale=0, start → count 0,1,2,3 on consecutive cycles. tick on each of the 1,2,3 updates, then done=1 with count=3. busy drops with done.
- Down auto-reload: limit=2, prescale=1 → count 2,1,0,2,1,0…, stepping every 2 cycles. wrap pulses when 0→2.
- Pause: up, limit=7, prescale=0; pause high for 3 cycles at count=4 → count holds 4 in HOLD, then resumes 5 the cycle after pause drops.
- Stop mid-run at count=5 → IDLE, busy=0, count stays 5, no done. A following start reloads 0.
- cfg_we with limit=9 during RUN → cfg_err pulse and the old limit is still used. The same write in DONE → accepted, no cfg_err.
- rst asserted mid-RUN at count=6 → next cycle count=0, busy=0, IDLE. limit=0 + start, up one-shot → done on first step with count=0.
